// File: rtl/octave_pkg.sv
// rtl/octave_pkg.sv - shared types and per-code segment lengths for octave_ctrl
package octave_pkg;

  localparam int LEN_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UP1 = 2'd0,
    UP2 = 2'd1,
    DN1 = 2'd2
  } step_t;

  typedef struct packed {
    step_t            step;
    logic             fb;
    logic [LEN_W-1:0] len;
  } cfg_t;

  localparam logic [LEN_W-1:0] LEN_1000 = 15'd2999;
  localparam logic [LEN_W-1:0] LEN_1100 = 15'd7999;
  localparam logic [LEN_W-1:0] LEN_1110 = 15'd14999;
  localparam logic [LEN_W-1:0] LEN_1111 = 15'd4999;
  localparam logic [LEN_W-1:0] LEN_0111 = 15'd9999;
  localparam logic [LEN_W-1:0] LEN_0011 = 15'd19998;
  localparam logic [LEN_W-1:0] LEN_0100 = 15'd2999;
  localparam logic [LEN_W-1:0] LEN_0001 = 15'd499;
  localparam logic [LEN_W-1:0] LEN_0010 = 15'd7999;

endpackage

// File: rtl/octave_ctrl_if.sv
// rtl/octave_ctrl_if.sv - control/status bundle between the effect sequencer and its user
interface octave_ctrl_if #(parameter int B = 15) ();

  logic         sample_stb;
  logic [3:0]   options;
  logic [3:0]   en;
  logic         we;
  logic [B-1:0] wr_addr;
  logic [B-1:0] rd_addr;
  logic         zero_wr;
  logic         fb_sel;
  logic         mute;
  logic [B-1:0] seg_len;
  logic [1:0]   state;

  modport master (
    output sample_stb, options, en,
    input  we, wr_addr, rd_addr, zero_wr, fb_sel, mute, seg_len, state
  );

  modport slave (
    input  sample_stb, options, en,
    output we, wr_addr, rd_addr, zero_wr, fb_sel, mute, seg_len, state
  );

endinterface

// File: rtl/octave_decode.sv
// rtl/octave_decode.sv - combinational options code to {step, fb, len} decode
module octave_decode
  import octave_pkg::*;
#(
  parameter int T = 20000
) (
  input  logic [3:0] options,
  output cfg_t       cfg,
  output logic       valid
);

  always_comb begin
    cfg   = '{step: UP1, fb: 1'b0, len: '0};
    valid = 1'b1;
    case (options)
      4'b1000: cfg = '{step: UP1, fb: 1'b0, len: LEN_1000};
      4'b1100: cfg = '{step: UP1, fb: 1'b0, len: LEN_1100};
      4'b1110: cfg = '{step: UP1, fb: 1'b0, len: LEN_1110};
      4'b1111: cfg = '{step: UP1, fb: 1'b1, len: LEN_1111};
      4'b0111: cfg = '{step: UP1, fb: 1'b1, len: LEN_0111};
      4'b0011: cfg = '{step: UP1, fb: 1'b1, len: LEN_0011};
      4'b0100: cfg = '{step: UP2, fb: 1'b0, len: LEN_0100};
      4'b0001: cfg = '{step: UP2, fb: 1'b0, len: LEN_0001};
      4'b0010: cfg = '{step: DN1, fb: 1'b0, len: LEN_0010};
      default: valid = 1'b0;
    endcase
    // A segment that does not fit the physical delay line cannot be served.
    if (int'(cfg.len) > T) valid = 1'b0;
  end

endmodule

// File: rtl/octave_ctrl.sv
// rtl/octave_ctrl.sv - delay-line pointer sequencer for the octave effect
// Optional zero-flush of a new segment is built when OCTAVE_CTRL_FLUSH_EN is defined.
module octave_ctrl
  import octave_pkg::*;
#(
  parameter int T = 20000,
  parameter int B = 15
) (
  input  logic         clk_48,
  input  logic         rst_n,
  octave_ctrl_if.slave bus
);

  localparam logic [B-1:0] ONE = B'(1);

  state_t       state_q, state_d;
  cfg_t         cfg_q, cfg_d, dec_cfg;
  logic         cfg_ok_q, cfg_ok_d, dec_valid;
  logic         we_q, we_d, zero_q, zero_d, fb_q, fb_d, mute_q, mute_d, phase_q, phase_d;
  logic [B-1:0] wr_q, wr_d, rd_q, rd_d, len_q, len_d;
  logic [B-1:0] last, step_amt, rd_sum, rd_next;
  logic         go, reload;
  logic         unused_en;

  octave_decode #(.T(T)) u_decode (
    .options (bus.options),
    .cfg     (dec_cfg),
    .valid   (dec_valid)
  );

  assign unused_en = ^{bus.en[3:2], bus.en[0]};
  assign go        = bus.en[1] & dec_valid;
  assign reload    = !cfg_ok_q || (dec_cfg != cfg_q);
  assign last      = len_q - ONE;

  always_comb begin
    step_amt = '0;
    case (cfg_q.step)
      UP1:     step_amt = B'(2);
      UP2:     step_amt = B'(4);
      DN1:     step_amt = phase_q ? ONE : '0;
      default: step_amt = '0;
    endcase
  end

  // Step is always smaller than the segment, so one subtract keeps rd in range.
  assign rd_sum  = rd_q + step_amt;
  assign rd_next = (rd_sum >= len_q) ? rd_sum - len_q : rd_sum;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cfg_ok_d = cfg_ok_q;
    len_d    = len_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    phase_d  = phase_q;
    we_d     = 1'b0;
    zero_d   = 1'b0;
    fb_d     = 1'b0;
    mute_d   = 1'b1;
    if (!go) begin
      state_d  = IDLE;
      cfg_ok_d = 1'b0;
      wr_d     = '0;
      rd_d     = '0;
      phase_d  = 1'b0;
    end else if (reload) begin
      cfg_d    = dec_cfg;
      cfg_ok_d = 1'b1;
      len_d    = B'(dec_cfg.len);
      wr_d     = '0;
      phase_d  = 1'b0;
`ifdef OCTAVE_CTRL_FLUSH_EN
      state_d  = FLUSH;
      rd_d     = '0;
      we_d     = 1'b1;
      zero_d   = 1'b1;
`else
      state_d  = RUN;
      rd_d     = ONE;
      mute_d   = 1'b0;
      fb_d     = dec_cfg.fb;
`endif
    end
`ifdef OCTAVE_CTRL_FLUSH_EN
    else if (state_q == FLUSH) begin
      if (wr_q == last) begin
        state_d = RUN;
        wr_d    = '0;
        rd_d    = ONE;
        mute_d  = 1'b0;
        fb_d    = cfg_q.fb;
      end else begin
        we_d   = 1'b1;
        zero_d = 1'b1;
        wr_d   = wr_q + ONE;
      end
    end
`endif
    else begin
      mute_d = 1'b0;
      fb_d   = cfg_q.fb;
      we_d   = bus.sample_stb;
      if (we_q) begin
        wr_d    = (wr_q == last) ? '0 : wr_q + ONE;
        rd_d    = rd_next;
        phase_d = ~phase_q;
      end
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      cfg_ok_q <= 1'b0;
      len_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      phase_q  <= 1'b0;
      we_q     <= 1'b0;
      zero_q   <= 1'b0;
      fb_q     <= 1'b0;
      mute_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      cfg_ok_q <= cfg_ok_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      phase_q  <= phase_d;
      we_q     <= we_d;
      zero_q   <= zero_d;
      fb_q     <= fb_d;
      mute_q   <= mute_d;
    end
  end

  assign bus.we      = we_q;
  assign bus.wr_addr = wr_q;
  assign bus.rd_addr = rd_q;
  assign bus.zero_wr = zero_q;
  assign bus.fb_sel  = fb_q;
  assign bus.mute    = mute_q;
  assign bus.seg_len = len_q;
  assign bus.state   = state_q;

endmodule

// File: doc/octave_ctrl.md
OCTAVE_CTRL -- requirements
Module: octave_ctrl

Interface
REQ-001 Parameter T, default 20000, delay-line depth in words.
REQ-002 Parameter B, default 15, address width.
REQ-003 clk_48  in  1  audio-domain clock; single clock domain.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 sample_stb  in  1  one-cycle pulse per audio sample.
REQ-006 options  in  4  effect selection code.
REQ-007 en  in  4  enable vector; only en[1] is used.
REQ-008 we  out  1  delay-line write enable.
REQ-009 wr_addr  out  B  delay-line write address.
REQ-010 rd_addr  out  B  delay-line read address.
REQ-011 zero_wr  out  1  selects write data = 0 (flush).
REQ-012 fb_sel  out  1  1 = write wet sum (IIR), 0 = write dry input (FIR).
REQ-013 mute  out  1  1 = datapath outputs dry x only.
REQ-014 seg_len  out  B  active segment length L.
REQ-015 state  out  2  IDLE=0, FLUSH=1, RUN=2.

Function
REQ-016 Decode (options -> step, fb, L): 1000->up1,FIR,2999; 1100->up1,FIR,7999; 1110->up1,FIR,14999; 1111->up1,IIR,4999; 0111->up1,IIR,9999; 0011->up1,IIR,19998; 0100->up2,FIR,2999; 0001->up2,FIR,499; 0010->dn1,FIR,7999; any other code is invalid.
REQ-017 options and en[1] are sampled every clock; cfg = decoded tuple, registered.
REQ-018 IDLE: we=0, mute=1; leave when en[1]=1 and options valid.
REQ-019 IDLE exit goes to FLUSH; wr_addr=0, zero_wr=1, we=1 every clock (not strobe-gated).
REQ-020 FLUSH: wr_addr increments per clock; after writing address L-1, next cycle enters RUN with wr_addr=0, rd_addr=1, zero_wr=0.
REQ-021 RUN: mute=0; we=1 only in the cycle sample_stb=1; pointers advance in the cycle after that write.
REQ-022 wr_addr advance: +1, wraps L-1 -> 0.
REQ-023 rd_addr advance: up1 +2, up2 +4, dn1 +1 on every second strobe (phase bit, cleared on RUN entry); sum >= L subtracts L (single subtract sufficient since step < L).
REQ-024 rd_addr and wr_addr are always < L.
REQ-025 fb_sel = cfg fb, held constant in RUN; 0 outside RUN.
REQ-026 Options change to a different valid code in RUN or FLUSH: restart FLUSH with the new L from address 0 the next cycle; mute=1.
REQ-027 en[1]=0 or invalid options in any state: IDLE next cycle, we=0 that cycle.
REQ-028 sample_stb during FLUSH/IDLE is ignored.
REQ-029 All outputs registered; decode-to-output latency 1 clock.

Reset
REQ-030 rst_n low: state=IDLE, we=0, zero_wr=0, fb_sel=0, mute=1, wr_addr=0, rd_addr=0, seg_len=0, phase=0, cfg=invalid.
REQ-031 Reset mid-FLUSH or mid-RUN aborts immediately; after release, sequence restarts from IDLE.

Configuration
REQ-032 Macro OCTAVE_CTRL_FLUSH_EN defined: FLUSH state as specified.
REQ-033 Macro undefined: FLUSH is never entered; IDLE exit and option changes go directly to RUN with wr_addr=0, rd_addr=1, zero_wr constant 0.

Structure
REQ-034 Shared package octave_pkg holds: state enum, step enum (UP1, UP2, DN1), cfg struct (step, fb, len), per-code length constants.
REQ-035 One sub-module octave_decode: combinational options -> cfg + valid.

Verification
REQ-036 Reset, en[1]=1, options=0001: FLUSH writes 0..498 over 499 clocks with zero_wr=1, then RUN, wr_addr=0, rd_addr=1.
REQ-037 RUN options=0001, 600 strobes: wr_addr wraps 498->0; rd_addr sequence 1,5,9,...,497,2 (501-499).
REQ-038 options=0010: rd_addr 1,1,2,2,3 over first five strobes.
REQ-039 options=1000 -> 0100 mid-RUN: next cycle FLUSH, mute=1, seg_len=2999, wr_addr=0.
REQ-040 en[1] drops mid-FLUSH: IDLE next cycle, we=0; options=0101 from IDLE: stays IDLE.
REQ-041 rst_n low 3 cycles during RUN with options=1111: all outputs at reset values asynchronously; fb_sel returns 1 only after re-entering RUN.
